// File: rtl/tank_pkg.sv
// Shared definitions for the tank controller and the blocks that sit beside
// it: FSM state type, default HID key bindings, wall flag bit positions and
// the sign-magnitude step helper also used by the bullet controller.
package tank_pkg;

   typedef enum logic {
      ST_ALIVE = 1'b0,
      ST_DEAD  = 1'b1
   } tank_state_e;

   // Default HID usage codes: arrow keys for motion, space for fire.
   localparam logic [7:0] DEF_KEY_UP   = 8'h52;
   localparam logic [7:0] DEF_KEY_DOWN = 8'h51;
   localparam logic [7:0] DEF_KEY_CW   = 8'h50;
   localparam logic [7:0] DEF_KEY_CCW  = 8'h4f;
   localparam logic [7:0] DEF_KEY_FIRE = 8'h2c;

   // Bit positions inside the {bottom, top, right, left} wall flag vector.
   localparam int WALL_LEFT   = 0;
   localparam int WALL_RIGHT  = 1;
   localparam int WALL_TOP    = 2;
   localparam int WALL_BOTTOM = 3;

   // Turns a sign flag and a 7-bit magnitude into a signed 8-bit step.
   function automatic logic signed [7:0] sm_to_step(input logic       neg,
                                                    input logic [6:0] mag);
      logic signed [7:0] m;
      m = $signed({1'b0, mag});
      return neg ? -m : m;
   endfunction

   // A key counts as pressed when any of the four report slots carries it.
   function automatic logic key_pressed(input logic [31:0] keycode,
                                        input logic [7:0]  key);
      return (keycode[7:0]   == key) || (keycode[15:8]  == key) ||
             (keycode[23:16] == key) || (keycode[31:24] == key);
   endfunction

endpackage

// File: rtl/tank_step_calc.sv
// Combinational step generator: scales the sin/cos magnitudes by SPEED,
// keeps 7 bits of (SPEED*mag)>>4 and applies the signs for forward motion.
// Screen y grows downward, so a positive sine moves the tank up (negative y).
module tank_step_calc
   import tank_pkg::*;
#(
   parameter int SPEED = 16
) (
   input  logic [7:0]        sin_i,
   input  logic [7:0]        cos_i,
   output logic signed [7:0] step_x_o,
   output logic signed [7:0] step_y_o
);

   logic [13:0] prod_x;
   logic [13:0] prod_y;
   logic [6:0]  mag_x;
   logic [6:0]  mag_y;

   // Scale magnitudes and re-apply signs for the forward (UP) direction.
   always_comb begin
      prod_x   = 14'(SPEED) * {7'd0, cos_i[6:0]};
      prod_y   = 14'(SPEED) * {7'd0, sin_i[6:0]};
      mag_x    = 7'(prod_x >> 4);
      mag_y    = 7'(prod_y >> 4);
      step_x_o = sm_to_step(cos_i[7], mag_x);
      step_y_o = sm_to_step(~sin_i[7], mag_y);
   end

endmodule

// File: rtl/tank_ctrl_p.sv
// Per-player tank controller. Once per frame it turns the keyboard report
// into fixed-point position, heading and a fire pulse, bounces the tank
// back off walls, and runs the ALIVE/DEAD hit-and-respawn sequence.
module tank_ctrl_p
   import tank_pkg::*;
#(
   parameter int         POS_W          = 13,
   parameter int         FRAC_BITS      = 3,
   parameter int         SPEED          = 16,
   parameter int         ANGLE_COUNT    = 45,
   parameter logic [7:0] KEY_UP         = DEF_KEY_UP,
   parameter logic [7:0] KEY_DOWN       = DEF_KEY_DOWN,
   parameter logic [7:0] KEY_CW         = DEF_KEY_CW,
   parameter logic [7:0] KEY_CCW        = DEF_KEY_CCW,
   parameter logic [7:0] KEY_FIRE       = DEF_KEY_FIRE,
   parameter int         SPAWN_X        = 300,
   parameter int         SPAWN_Y        = 250,
   parameter int         COOLDOWN       = 30,
   parameter int         RESPAWN_FRAMES = 120,
   parameter int         TANK_SIZE      = 10
) (
   input  logic             frame_clk,
   input  logic             Reset,
   input  logic [31:0]      keycode,
   input  logic [7:0]       sin,
   input  logic [7:0]       cos,
   input  logic [3:0]       wall_hit,
   input  logic             hit,
   input  logic [1:0]       game_end,
   output logic [9:0]       TankX,
   output logic [9:0]       TankY,
   output logic [9:0]       TankS,
   output logic [POS_W-1:0] TankXStep,
   output logic [POS_W-1:0] TankYStep,
   output logic [5:0]       Angle,
   output logic             ShootBullet,
   output logic             Alive
);

   localparam int               CD_W        = $clog2(COOLDOWN + 1);
   localparam int               RSP_W       = $clog2(RESPAWN_FRAMES + 1);
   localparam logic [POS_W-1:0] SPAWN_X_POS = POS_W'(SPAWN_X << FRAC_BITS);
   localparam logic [POS_W-1:0] SPAWN_Y_POS = POS_W'(SPAWN_Y << FRAC_BITS);
   localparam logic [5:0]       ANGLE_MAX   = 6'(ANGLE_COUNT - 1);

   tank_state_e       state_q, state_d;
   logic [POS_W-1:0]  pos_x_q, pos_x_d;
   logic [POS_W-1:0]  pos_y_q, pos_y_d;
   logic [POS_W-1:0]  step_x_q, step_x_d;
   logic [POS_W-1:0]  step_y_q, step_y_d;
   logic [5:0]        angle_q, angle_d;
   logic              shoot_q, shoot_d;
   logic [CD_W-1:0]   cd_q, cd_d;
   logic [RSP_W-1:0]  rsp_q, rsp_d;
   logic              fire_prev_q, fire_prev_d;

   logic              key_up, key_down, key_cw, key_ccw, key_fire;
   logic              any_wall;
   logic signed [7:0] fwd_x, fwd_y;
   logic signed [9:0] mv_x, mv_y;
   logic [POS_W-1:0]  ext_x, ext_y;

   tank_step_calc #(
      .SPEED (SPEED)
   ) u_step_calc (
      .sin_i    (sin),
      .cos_i    (cos),
      .step_x_o (fwd_x),
      .step_y_o (fwd_y)
   );

   assign key_up   = key_pressed(keycode, KEY_UP);
   assign key_down = key_pressed(keycode, KEY_DOWN);
   assign key_cw   = key_pressed(keycode, KEY_CW);
   assign key_ccw  = key_pressed(keycode, KEY_CCW);
   assign key_fire = key_pressed(keycode, KEY_FIRE);
   assign any_wall = wall_hit[WALL_LEFT] | wall_hit[WALL_RIGHT] |
                     wall_hit[WALL_TOP]  | wall_hit[WALL_BOTTOM];

   // Motion vector: forward step, reversed for DOWN, then -2x on a wall.
   always_comb begin
      // NOTE: blocking assignments here build the value up in sequence; each
      // line sees the result of the one before, as intended for combinational logic.
      mv_x = 10'(fwd_x);
      mv_y = 10'(fwd_y);
      if (!key_up) begin
         mv_x = -mv_x;
         mv_y = -mv_y;
      end
      if (any_wall) begin
         mv_x = -(mv_x <<< 1);
         mv_y = -(mv_y <<< 1);
      end
      ext_x = POS_W'(mv_x);
      ext_y = POS_W'(mv_y);
   end

   // Next-state logic: game_end override, respawn countdown, or live play.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves one unassigned
      // (which would infer a latch).
      state_d     = state_q;
      pos_x_d     = pos_x_q;
      pos_y_d     = pos_y_q;
      step_x_d    = '0;
      step_y_d    = '0;
      angle_d     = angle_q;
      shoot_d     = 1'b0;
      cd_d        = cd_q;
      rsp_d       = rsp_q;
      fire_prev_d = key_fire;

      if (game_end != 2'b00) begin
         state_d     = ST_ALIVE;
         pos_x_d     = SPAWN_X_POS;
         pos_y_d     = SPAWN_Y_POS;
         angle_d     = '0;
         cd_d        = '0;
         rsp_d       = '0;
         fire_prev_d = 1'b0;
      end else if (state_q == ST_DEAD) begin
         if (rsp_q == '0) begin
            state_d = ST_ALIVE;
            pos_x_d = SPAWN_X_POS;
            pos_y_d = SPAWN_Y_POS;
            angle_d = '0;
            cd_d    = '0;
         end else begin
            rsp_d = rsp_q - 1'b1;
         end
      end else if (hit) begin
         state_d = ST_DEAD;
         rsp_d   = RSP_W'(RESPAWN_FRAMES - 1);
      end else begin
         if (cd_q != '0) cd_d = cd_q - 1'b1;

         if (key_up || key_down) begin
            pos_x_d  = pos_x_q + ext_x;
            pos_y_d  = pos_y_q + ext_y;
            step_x_d = ext_x;
            step_y_d = ext_y;
         end else if (key_cw && !any_wall) begin
            angle_d = (angle_q == ANGLE_MAX) ? '0 : angle_q + 1'b1;
         end else if (key_ccw && !any_wall) begin
            angle_d = (angle_q == '0) ? ANGLE_MAX : angle_q - 1'b1;
         end

         if (key_fire && !fire_prev_q && (cd_q == '0)) begin
            shoot_d = 1'b1;
            cd_d    = CD_W'(COOLDOWN);
         end
      end
   end

   // Frame-rate state registers with asynchronous reset to the spawn point.
   always_ff @(posedge frame_clk or posedge Reset) begin
      // NOTE: non-blocking assignments so every register samples the pre-edge
      // values, independent of statement order.
      if (Reset) begin
         state_q     <= ST_ALIVE;
         pos_x_q     <= SPAWN_X_POS;
         pos_y_q     <= SPAWN_Y_POS;
         step_x_q    <= '0;
         step_y_q    <= '0;
         angle_q     <= '0;
         shoot_q     <= 1'b0;
         cd_q        <= '0;
         rsp_q       <= '0;
         fire_prev_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pos_x_q     <= pos_x_d;
         pos_y_q     <= pos_y_d;
         step_x_q    <= step_x_d;
         step_y_q    <= step_y_d;
         angle_q     <= angle_d;
         shoot_q     <= shoot_d;
         cd_q        <= cd_d;
         rsp_q       <= rsp_d;
         fire_prev_q <= fire_prev_d;
      end
   end

   assign TankX       = 10'(pos_x_q >> FRAC_BITS);
   assign TankY       = 10'(pos_y_q >> FRAC_BITS);
   assign TankS       = 10'(TANK_SIZE);
   assign TankXStep   = step_x_q;
   assign TankYStep   = step_y_q;
   assign Angle       = angle_q;
   assign ShootBullet = shoot_q;
   assign Alive       = (state_q == ST_ALIVE);

endmodule

// File: tb/tb_tank_ctrl_p.sv
// Directed bench for tank_ctrl_p: a table of single-frame vectors with
// hand-computed results, then hand-written fire, hit/respawn and reset runs.
module tb_tank_ctrl_p;

   localparam logic [31:0] K_NONE = 32'h0000_0000;
   localparam logic [31:0] K_UP   = 32'h0000_0052;
   localparam logic [31:0] K_CW   = 32'h0000_0050;
   localparam logic [31:0] K_CCW  = 32'h0000_004f;
   localparam logic [31:0] K_FIRE = 32'h0000_002c;
   localparam logic [31:0] K_UPFR = 32'h0000_2c52;

   logic        frame_clk = 1'b0;
   logic        Reset     = 1'b0;
   logic [31:0] keycode;
   logic [7:0]  sin, cos;
   logic [3:0]  wall_hit;
   logic        hit;
   logic [1:0]  game_end;
   logic [9:0]  TankX, TankY, TankS;
   logic [12:0] TankXStep, TankYStep;
   logic [5:0]  Angle;
   logic        ShootBullet, Alive;

   int checks   = 0;
   int failures = 0;

   tank_ctrl_p dut (
      .frame_clk   (frame_clk),
      .Reset       (Reset),
      .keycode     (keycode),
      .sin         (sin),
      .cos         (cos),
      .wall_hit    (wall_hit),
      .hit         (hit),
      .game_end    (game_end),
      .TankX       (TankX),
      .TankY       (TankY),
      .TankS       (TankS),
      .TankXStep   (TankXStep),
      .TankYStep   (TankYStep),
      .Angle       (Angle),
      .ShootBullet (ShootBullet),
      .Alive       (Alive)
   );

   always #5 frame_clk = ~frame_clk;

   typedef struct {
      logic [31:0] kc;
      logic [7:0]  s;
      logic [7:0]  c;
      logic [3:0]  w;
      logic [1:0]  ge;
      int          ex, ey, exs, eys, ea;
   } vec_t;

   vec_t vecs[15];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Drive one frame of inputs and sample the outputs 1 unit after the edge.
   task automatic frame(input logic [31:0] kc, input logic [7:0] s, input logic [7:0] c,
                        input logic [3:0] w, input logic h, input logic [1:0] ge);
      keycode  = kc;
      sin      = s;
      cos      = c;
      wall_hit = w;
      hit      = h;
      game_end = ge;
      @(posedge frame_clk);
      #1;
   endtask

   task automatic fire_frame(input logic press, output logic sh);
      frame(press ? K_FIRE : K_NONE, 8'h00, 8'h7f, 4'h0, 1'b0, 2'd0);
      sh = ShootBullet;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int   pulses;
      int   bad_alive, bad_shoot, bad_step, bad_angle;
      logic sh;

      //         keycode        sin    cos    wall  ge    X    Y    Xstep Ystep Angle
      vecs[0]  = '{K_NONE,       8'h00, 8'h7f, 4'h0, 2'd0, 300, 250, 0,    0,    0};
      vecs[1]  = '{K_UP,         8'h00, 8'h7f, 4'h0, 2'd0, 315, 250, 127,  0,    0};
      vecs[2]  = '{32'h0051_0000, 8'h00, 8'h7f, 4'h0, 2'd0, 300, 250, 8065, 0,    0};
      vecs[3]  = '{K_UP,         8'h40, 8'h80, 4'h0, 2'd0, 300, 242, 0,    8128, 0};
      vecs[4]  = '{K_UP,         8'h00, 8'h7f, 4'h2, 2'd0, 268, 242, 7938, 0,    0};
      vecs[5]  = '{K_CW,         8'h00, 8'h7f, 4'h1, 2'd0, 268, 242, 0,    0,    0};
      vecs[6]  = '{K_CCW,        8'h00, 8'h7f, 4'h0, 2'd0, 268, 242, 0,    0,    44};
      vecs[7]  = '{32'h5000_0000, 8'h00, 8'h7f, 4'h0, 2'd0, 268, 242, 0,    0,    0};
      vecs[8]  = '{32'h0000_4f00, 8'h00, 8'h7f, 4'h0, 2'd0, 268, 242, 0,    0,    44};
      vecs[9]  = '{32'h0000_0051, 8'hc0, 8'h20, 4'h0, 2'd0, 264, 234, 8160, 8128, 44};
      vecs[10] = '{32'h0000_5052, 8'h00, 8'h7f, 4'h0, 2'd0, 280, 234, 127,  0,    44};
      vecs[11] = '{32'h5100_0000, 8'h00, 8'h7f, 4'h8, 2'd0, 311, 234, 254,  0,    44};
      vecs[12] = '{K_UP,         8'h00, 8'h7f, 4'h0, 2'd2, 300, 250, 0,    0,    0};
      vecs[13] = '{K_CCW,        8'h00, 8'h7f, 4'h0, 2'd1, 300, 250, 0,    0,    0};
      vecs[14] = '{K_UP,         8'h00, 8'h7f, 4'h0, 2'd0, 315, 250, 127,  0,    0};

      keycode  = K_NONE;
      sin      = 8'h00;
      cos      = 8'h7f;
      wall_hit = 4'h0;
      hit      = 1'b0;
      game_end = 2'd0;

      // Asynchronous reset before any clock edge.
      #1 Reset = 1'b1;
      #2;
      check("reset_x", TankX, 300);
      check("reset_y", TankY, 250);
      check("reset_s", TankS, 10);
      check("reset_xstep", TankXStep, 0);
      check("reset_ystep", TankYStep, 0);
      check("reset_angle", Angle, 0);
      check("reset_shoot", ShootBullet, 0);
      check("reset_alive", Alive, 1);
      @(negedge frame_clk);
      Reset = 1'b0;
      @(posedge frame_clk);
      #1;

      for (int i = 0; i < 15; i++) begin
         frame(vecs[i].kc, vecs[i].s, vecs[i].c, vecs[i].w, 1'b0, vecs[i].ge);
         check($sformatf("vec%0d_x", i), TankX, vecs[i].ex);
         check($sformatf("vec%0d_y", i), TankY, vecs[i].ey);
         check($sformatf("vec%0d_xstep", i), TankXStep, vecs[i].exs);
         check($sformatf("vec%0d_ystep", i), TankYStep, vecs[i].eys);
         check($sformatf("vec%0d_angle", i), Angle, vecs[i].ea);
         check($sformatf("vec%0d_shoot", i), ShootBullet, 0);
         check($sformatf("vec%0d_alive", i), Alive, 1);
      end

      // Fire held 40 frames: only the first frame pulses.
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         fire_frame(1'b1, sh);
         if (i == 0) check("fire_first_edge", sh, 1);
         pulses += int'(sh);
      end
      check("fire_held_40_pulses", pulses, 1);

      // Release then press: cooldown already expired, so this pulses (frame p).
      fire_frame(1'b0, sh);
      fire_frame(1'b1, sh);
      check("fire_repress_after_hold", sh, 1);
      for (int i = 0; i < 9; i++) fire_frame(1'b0, sh);
      fire_frame(1'b1, sh);
      check("fire_repress_frame10", sh, 0);
      for (int i = 0; i < 19; i++) fire_frame(1'b0, sh);
      fire_frame(1'b1, sh);
      check("fire_repress_frame30", sh, 0);
      fire_frame(1'b0, sh);

      // Frame p+32: fire while moving.
      frame(K_UPFR, 8'h00, 8'h7f, 4'h0, 1'b0, 2'd0);
      check("fire_move_shoot", ShootBullet, 1);
      check("fire_move_xstep", TankXStep, 127);
      check("fire_move_x", TankX, 331);
      frame(K_UPFR, 8'h00, 8'h7f, 4'h0, 1'b0, 2'd0);
      check("fire_pulse_one_frame", ShootBullet, 0);

      for (int i = 0; i < 31; i++) fire_frame(1'b0, sh);
      frame(K_CCW, 8'h00, 8'h7f, 4'h0, 1'b0, 2'd0);
      check("pre_hit_angle", Angle, 44);

      // Hit with a fire edge in the same frame: hit wins.
      frame(K_UPFR, 8'h00, 8'h7f, 4'h0, 1'b1, 2'd0);
      check("hit_alive", Alive, 0);
      check("hit_no_shoot", ShootBullet, 0);

      bad_alive = 0;
      bad_shoot = 0;
      bad_step  = 0;
      bad_angle = 0;
      for (int i = 1; i < 120; i++) begin
         frame((i == 119) ? K_NONE : ((i % 2) != 0) ? K_UPFR : K_CW,
               8'h00, 8'h7f, 4'h0, ((i % 7) == 0), 2'd0);
         if (Alive !== 1'b0) bad_alive++;
         if (ShootBullet !== 1'b0) bad_shoot++;
         if (TankXStep !== 13'd0 || TankYStep !== 13'd0) bad_step++;
         if (Angle !== 6'd44) bad_angle++;
      end
      check("dead_alive_frames", bad_alive, 0);
      check("dead_no_shoot", bad_shoot, 0);
      check("dead_no_motion", bad_step, 0);
      check("dead_no_rotation", bad_angle, 0);

      frame(K_NONE, 8'h00, 8'h7f, 4'h0, 1'b0, 2'd0);
      check("respawn_alive", Alive, 1);
      check("respawn_x", TankX, 300);
      check("respawn_y", TankY, 250);
      check("respawn_angle", Angle, 0);
      fire_frame(1'b1, sh);
      check("respawn_fire_ready", sh, 1);

      // Reset in the middle of a respawn returns to ALIVE at spawn at once.
      frame(K_UP, 8'h00, 8'h7f, 4'h0, 1'b0, 2'd0);
      check("pre_reset_x", TankX, 315);
      frame(K_NONE, 8'h00, 8'h7f, 4'h0, 1'b1, 2'd0);
      for (int i = 0; i < 5; i++) frame(K_NONE, 8'h00, 8'h7f, 4'h0, 1'b0, 2'd0);
      check("mid_respawn_dead", Alive, 0);
      Reset = 1'b1;
      #1;
      check("mid_reset_alive", Alive, 1);
      check("mid_reset_x", TankX, 300);
      @(negedge frame_clk);
      Reset = 1'b0;
      @(posedge frame_clk);
      #1;
      frame(K_NONE, 8'h00, 8'h7f, 4'h0, 1'b0, 2'd0);
      check("post_reset_alive", Alive, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
